fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that produces the 32-bit instruction stream the decoder consumes. It issues word reads on the instruction-memory bus, buffers returned words with their PC in a 2-entry FIFO, and presents them with a valid/ready handshake. It also accepts redirects from branch/jump resolution, flushing stale state and restarting at the target.

## Interface
- RESET_ADDR, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0
- NOP_INST, 32'h0000_0013, value driven on `instruction` when no entry is valid and on fault entries
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- imem_req  output  1  bus request; a transfer completes in any cycle with imem_req && (imem_ack || imem_err)
- imem_addr  output  32  word address of current request, bits [1:0] always 0
- imem_data  input  32  read data, sampled when imem_ack
- imem_ack  input  1  transfer done, data valid; may assert in the same cycle as imem_req rises
- imem_err  input  1  transfer done with bus error; wins if asserted with imem_ack
- redirect  input  1  one-cycle pulse: discard fetched/in-flight words, restart at redirect_addr
- redirect_addr  input  32  target; bits [1:0] ignored (forced to 0)
- inst_valid  output  1  FIFO head valid
- inst_ready  input  1  consumer accepts head this cycle
- instruction  output  32  head instruction word
- inst_pc  output  32  address the head was fetched from
- inst_fault  output  1  head came from a bus error

## Operation
- States: FETCH, DRAIN, HALT. Reset state FETCH, fetch_pc = RESET_ADDR, FIFO empty.
- FIFO: 2 entries of {pc, word, fault}; count 0..2; full = (count == 2). Pop when inst_valid && inst_ready; push on accepted completion. Simultaneous push and pop at count 1 or 2 keeps count unchanged.
- FETCH: imem_req = !full; imem_addr = fetch_pc. On ack: push {fetch_pc, imem_data, 0}, fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0). On err: push {fetch_pc, NOP_INST, 1}, go HALT.
- full can only rise via a completion, so imem_req never drops and imem_addr never changes while a transfer is pending.
- DRAIN: imem_req = 1, imem_addr held at the old address; completion (ack or err) discarded, no push; then FETCH with fetch_pc = latched target.
- HALT: imem_req = 0; FIFO continues to drain to consumer; only redirect leaves HALT.
- Redirect (highest priority, any state): FIFO count -> 0 next cycle (pop that cycle ignored); target latched.
  - FETCH with imem_req high and no completion this cycle -> DRAIN.
  - FETCH with completion this cycle, or imem_req low -> completion discarded, FETCH with fetch_pc = target.
  - DRAIN without completion -> stay DRAIN, target overwritten by newest redirect_addr. DRAIN with completion -> FETCH at new target.
  - HALT -> FETCH at target.
- Outputs when inst_valid = 0: instruction = NOP_INST, inst_pc = 0, inst_fault = 0.

## Timing
- Reset values: imem_req 0 while rst_n low, imem_addr RESET_ADDR, inst_valid 0, instruction NOP_INST, inst_pc 0, inst_fault 0.
- First cycle after rst_n deasserts: imem_req = 1, imem_addr = RESET_ADDR.
- Latency: completion in cycle N -> inst_valid in N+1 with that entry at head (if FIFO was empty). Next request address visible in N+1.
- Throughput: zero-wait memory and inst_ready held high -> one instruction per cycle, count steady at 1.
- Consumer stalled: two words fetched, then imem_req low until a pop frees a slot; request reasserts cycle after the pop.
- Redirect in cycle N: inst_valid = 0 in N+1; first request to target in N+1 (FETCH) or cycle after drain completion (DRAIN).
- rst_n assertion mid-transfer: immediate return to reset values; pending bus response ignored.

## Test plan
- Reset release, zero-wait memory returning addr as data, inst_ready = 1 -> inst_pc/instruction 0x0,0x4,0x8,... one per cycle, starting 2 cycles after release.
- inst_ready = 0 for 10 cycles -> exactly 2 requests (0x0, 0x4), imem_req low thereafter; raising inst_ready resumes at 0x8 with no lost or duplicated word.
- Memory 3-cycle wait on 0x8, redirect to 0x100 in its first wait cycle -> imem_addr stays 0x8 until ack, that word not delivered, next request 0x100, first delivered inst_pc 0x100.
- redirect to 0x203 in same cycle as ack of 0x10 -> 0x10 word dropped, next request 0x200.
- imem_err on 0xC -> entry inst_pc 0xC, instruction 32'h00000013, inst_fault 1; no further requests until redirect to 0x40, then fetch resumes at 0x40.
- fetch_pc 0xFFFF_FFFC acked -> next request 0x0000_0000.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-unit signal bundle: instruction-memory bus, redirect input and the
// decoded-stream handshake toward the decoder.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_ack;
  logic        imem_err;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic        inst_fault;

  modport master (
    output imem_req, imem_addr, inst_valid, instruction, inst_pc, inst_fault,
    input  imem_data, imem_ack, imem_err, redirect, redirect_addr, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, instruction, inst_pc, inst_fault,
    output imem_data, imem_ack, imem_err, redirect, redirect_addr, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: word reads on the imem bus, 2-entry {pc, word, fault}
// FIFO toward the decoder, and redirect handling that drains in-flight transfers.
module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {FETCH, DRAIN, HALT} state_t;

  state_t      state_reg, state_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;
  logic [31:0] target_reg, target_next;
  logic [1:0]  count_reg, count_next;
  logic        rd_ptr_reg, rd_ptr_next;
  logic        wr_ptr_reg, wr_ptr_next;
  logic        req_reg, req_next;

  logic [31:0] pc_mem   [2];
  logic [31:0] word_mem [2];
  logic        fault_mem[2];

  logic        completion;
  logic        pop;
  logic        push;
  logic [31:0] redirect_tgt;

  assign completion   = req_reg && (bus.imem_ack || bus.imem_err);
  assign pop          = (count_reg != 2'd0) && bus.inst_ready;
  assign push         = (state_reg == FETCH) && completion && !bus.redirect;
  assign redirect_tgt = bus.redirect_addr & 32'hFFFF_FFFC;

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    target_next   = target_reg;
    count_next    = count_reg;
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;

    if (bus.redirect) begin
      count_next  = 2'd0;
      rd_ptr_next = 1'b0;
      wr_ptr_next = 1'b0;
      unique case (state_reg)
        FETCH: begin
          // A pending transfer cannot be abandoned; wait it out in DRAIN.
          if (req_reg && !completion) begin
            state_next  = DRAIN;
            target_next = redirect_tgt;
          end else begin
            fetch_pc_next = redirect_tgt;
          end
        end
        DRAIN: begin
          if (!completion) begin
            target_next = redirect_tgt;
          end else begin
            state_next    = FETCH;
            fetch_pc_next = redirect_tgt;
          end
        end
        default: begin
          state_next    = FETCH;
          fetch_pc_next = redirect_tgt;
        end
      endcase
    end else begin
      count_next = count_reg + {1'b0, push} - {1'b0, pop};
      if (push) wr_ptr_next = ~wr_ptr_reg;
      if (pop)  rd_ptr_next = ~rd_ptr_reg;
      unique case (state_reg)
        FETCH: begin
          if (completion) begin
            if (bus.imem_err) state_next    = HALT;
            else              fetch_pc_next = fetch_pc_reg + 32'd4;
          end
        end
        DRAIN: begin
          if (completion) begin
            state_next    = FETCH;
            fetch_pc_next = target_reg;
          end
        end
        default: ;
      endcase
    end

    // Request is registered from next state, so a freed slot re-requests one cycle later.
    req_next = (state_next == DRAIN) || ((state_next == FETCH) && (count_next != 2'd2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= FETCH;
      fetch_pc_reg <= RESET_ADDR;
      target_reg   <= RESET_ADDR;
      count_reg    <= 2'd0;
      rd_ptr_reg   <= 1'b0;
      wr_ptr_reg   <= 1'b0;
      req_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      target_reg   <= target_next;
      count_reg    <= count_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      req_reg      <= req_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == 1'(gi))) begin
          pc_mem[gi]    <= fetch_pc_reg;
          word_mem[gi]  <= bus.imem_err ? NOP_INST : bus.imem_data;
          fault_mem[gi] <= bus.imem_err;
        end
      end
    end
  endgenerate

  assign bus.imem_req    = req_reg;
  assign bus.imem_addr   = fetch_pc_reg;
  assign bus.inst_valid  = (count_reg != 2'd0);
  assign bus.instruction = bus.inst_valid ? word_mem[rd_ptr_reg]  : NOP_INST;
  assign bus.inst_pc     = bus.inst_valid ? pc_mem[rd_ptr_reg]    : 32'd0;
  assign bus.inst_fault  = bus.inst_valid ? fault_mem[rd_ptr_reg] : 1'b0;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a queue-based model of the fetch stage is
// stepped each cycle and every DUT output is compared against it.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int M_FETCH = 0, M_DRAIN = 1, M_HALT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus ();
  fetch_unit #(.RESET_ADDR(32'h0), .NOP_INST(NOP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] pc;
    logic [31:0] w;
    logic        f;
  } ent_t;

  ent_t        q[$];
  int          mode;
  logic [31:0] pc;
  logic [31:0] tgt;
  logic        exp_req;
  int          n_checks = 0;
  int          n_fail = 0;
  int          wt = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mode    = M_FETCH;
    pc      = 32'h0;
    tgt     = 32'h0;
    exp_req = 1'b0;
  endtask

  task automatic model_step(input logic a, input logic e, input logic r,
                            input logic [31:0] ra, input logic rdy);
    logic done;
    logic [31:0] t;
    done = exp_req && (a || e);
    t = ra & 32'hFFFF_FFFC;
    if (r) begin
      q.delete();
      if (mode == M_FETCH) begin
        if (exp_req && !done) begin mode = M_DRAIN; tgt = t; end
        else pc = t;
      end else if (mode == M_DRAIN) begin
        if (!done) tgt = t;
        else begin mode = M_FETCH; pc = t; end
      end else begin
        mode = M_FETCH; pc = t;
      end
    end else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (mode == M_FETCH && done) begin
        if (e) begin
          q.push_back('{pc: pc, w: NOP, f: 1'b1});
          mode = M_HALT;
        end else begin
          q.push_back('{pc: pc, w: memf(pc), f: 1'b0});
          pc = pc + 32'd4;
        end
      end else if (mode == M_DRAIN && done) begin
        mode = M_FETCH; pc = tgt;
      end
    end
    exp_req = (mode == M_DRAIN) || (mode == M_FETCH && q.size() < 2);
  endtask

  task automatic check_outputs();
    logic v;
    v = (q.size() != 0);
    check("imem_req", 32'(bus.imem_req), 32'(exp_req));
    if (exp_req || !rst_n) check("imem_addr", bus.imem_addr, pc);
    check("inst_valid", 32'(bus.inst_valid), 32'(v));
    check("instruction", bus.instruction, v ? q[0].w : NOP);
    check("inst_pc", bus.inst_pc, v ? q[0].pc : 32'h0);
    check("inst_fault", 32'(bus.inst_fault), v ? 32'(q[0].f) : 32'h0);
  endtask

  task automatic cycle(input logic a, input logic e, input logic r,
                       input logic [31:0] ra, input logic rdy);
    @(negedge clk);
    check_outputs();
    bus.imem_ack      = a;
    bus.imem_err      = e;
    bus.imem_data     = a ? memf(pc) : 32'hDEAD_BEEF;
    bus.redirect      = r;
    bus.redirect_addr = ra;
    bus.inst_ready    = rdy;
    $display("cyc t=%0t ack=%0b err=%0b redir=%0b->%h rdy=%0b | req=%0b addr=%h v=%0b pc=%h ins=%h f=%0b",
             $time, a, e, r, ra, rdy, bus.imem_req, bus.imem_addr, bus.inst_valid,
             bus.inst_pc, bus.instruction, bus.inst_fault);
    model_step(a, e, r, ra, rdy);
  endtask

  // Asserts reset just after a rising edge (mid-transfer), with a stray ack present.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.imem_ack = 1'b1; bus.imem_err = 1'b0; bus.imem_data = 32'hDEAD_BEEF;
    bus.redirect = 1'b0; bus.redirect_addr = 32'h0; bus.inst_ready = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check_outputs();
    end
    rst_n = 1'b1;
    bus.imem_ack = 1'b0;
    model_step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    logic a, e, r, rdy;
    logic [31:0] ra;

    do_reset();
    // Zero-wait memory, consumer always ready.
    repeat (12) cycle(1, 0, 0, 0, 1);
    // Stalled consumer, then resume.
    do_reset();
    repeat (10) cycle(1, 0, 0, 0, 0);
    repeat (6) cycle(1, 0, 0, 0, 1);
    // Wait states on 0x8 with a redirect in the first wait cycle.
    do_reset();
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 1, 32'h100, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    repeat (4) cycle(1, 0, 0, 0, 1);
    // Redirect coincident with the ack of 0x10.
    do_reset();
    repeat (4) cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 1, 32'h203, 1);
    repeat (4) cycle(1, 0, 0, 0, 1);
    // Bus error on 0xC, halt, then redirect.
    do_reset();
    repeat (3) cycle(1, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 1);
    repeat (5) cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 1, 32'h40, 1);
    repeat (4) cycle(1, 0, 0, 0, 1);
    // Address wrap at the top of memory.
    cycle(0, 0, 1, 32'hFFFF_FFF8, 1);
    repeat (5) cycle(1, 0, 0, 0, 1);

    // Randomized traffic with wait states, errors, redirects and stalls.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      a = 1'b0; e = 1'b0;
      if (exp_req) begin
        if (wt == 0) begin
          if ($urandom_range(99) < 4) e = 1'b1; else a = 1'b1;
          if (e && $urandom_range(1) == 0) a = 1'b1;
          wt = ($urandom_range(3) == 0) ? int'($urandom_range(3)) : 0;
        end else begin
          wt--;
        end
      end else begin
        a = ($urandom_range(9) == 0);
      end
      r   = ($urandom_range(99) < 5) || (mode == M_HALT && $urandom_range(7) == 0);
      ra  = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                     : 32'($urandom_range(1023));
      rdy = ($urandom_range(99) < 70);
      cycle(a, e, r, ra, rdy);
      if (i == 1500) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
